// File: rtl/data_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, bus owners and
// memory strobe encoding.
package data_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  // Strobe bit 0 drives memread, bit 1 drives memwrite.
  localparam logic [1:0] STROBE_NONE  = 2'b00;
  localparam logic [1:0] STROBE_READ  = 2'b01;
  localparam logic [1:0] STROBE_WRITE = 2'b10;

  function automatic logic [1:0] strobe_for(input logic we);
    return we ? STROBE_WRITE : STROBE_READ;
  endfunction

endpackage

// File: rtl/data_arb_pick.sv
// Grant selection between CPU and DMA. Round-robin on last owner when
// DATA_ARB_ROUND_ROBIN_EN is defined, otherwise fixed CPU priority.
module data_arb_pick
  import data_arb_pkg::*;
(
  input  logic   cpu_req_i,
  input  logic   dma_req_i,
  output owner_e grant_o
`ifdef DATA_ARB_ROUND_ROBIN_EN
  ,
  input  owner_e last_i
`endif
);

`ifdef DATA_ARB_ROUND_ROBIN_EN
  // Under contention the master that did not win last time gets the port.
  always_comb begin
    grant_o = OWN_CPU;
    if (cpu_req_i && dma_req_i) begin
      grant_o = (last_i == OWN_CPU) ? OWN_DMA : OWN_CPU;
    end else if (dma_req_i) begin
      grant_o = OWN_DMA;
    end else begin
      grant_o = OWN_CPU;
    end
  end
`else
  // CPU always wins; DMA only gets the port when the CPU is quiet.
  always_comb begin
    grant_o = OWN_CPU;
    if (cpu_req_i) begin
      grant_o = OWN_CPU;
    end else if (dma_req_i) begin
      grant_o = OWN_DMA;
    end else begin
      grant_o = OWN_CPU;
    end
  end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Serialises CPU and DMA accesses onto one data-memory port with a busy
// watchdog. Define DATA_ARB_ROUND_ROBIN_EN for round-robin arbitration.
module data_mem_arbiter
  import data_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  input  logic [3:0]        cpu_sign_mask_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  input  logic [3:0]        dma_sign_mask_i,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic              dma_ack_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_sign_mask_o,
  output logic              mem_memread_o,
  output logic              mem_memwrite_o,
  input  logic [DATA_W-1:0] mem_read_data_i,
  input  logic              mem_busy_i,
  output logic              err_timeout_o
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              grant_s;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          mask_q, mask_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc_s;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
  logic                err_q, err_d;
  logic                active_s;
  logic [1:0]          strobe_s;
`ifdef DATA_ARB_ROUND_ROBIN_EN
  owner_e              last_q, last_d;
`endif

  data_arb_pick u_pick (
    .cpu_req_i (cpu_req_i),
    .dma_req_i (dma_req_i),
    .grant_o   (grant_s)
`ifdef DATA_ARB_ROUND_ROBIN_EN
    ,
    .last_i    (last_q)
`endif
  );

  assign cnt_inc_s = cnt_q + CNT_W'(1);

  // Next-state logic: latch the winner in IDLE, watch busy in WAIT.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    err_d       = err_q;
`ifdef DATA_ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cpu_req_i || dma_req_i) begin
          owner_d = grant_s;
          cnt_d   = '0;
          state_d = ST_ISSUE;
          if (grant_s == OWN_CPU) begin
            we_d    = cpu_we_i;
            addr_d  = cpu_addr_i;
            wdata_d = cpu_wdata_i;
            mask_d  = cpu_sign_mask_i;
          end else begin
            we_d    = dma_we_i;
            addr_d  = dma_addr_i;
            wdata_d = dma_wdata_i;
            mask_d  = dma_sign_mask_i;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!mem_busy_i) begin
          state_d = ST_DONE;
          if (owner_q == OWN_CPU) begin
            cpu_rdata_d = mem_read_data_i;
          end else begin
            dma_rdata_d = mem_read_data_i;
          end
        end else if (cnt_inc_s == CNT_W'(MAX_WAIT)) begin
          // Watchdog expiry: finish the access with zero data and flag it.
          cnt_d   = cnt_inc_s;
          state_d = ST_DONE;
          err_d   = 1'b1;
          if (owner_q == OWN_CPU) begin
            cpu_rdata_d = '0;
          end else begin
            dma_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef DATA_ARB_ROUND_ROBIN_EN
        last_d  = owner_q;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= 4'h0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      err_q       <= 1'b0;
`ifdef DATA_ARB_ROUND_ROBIN_EN
      last_q      <= OWN_DMA;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      err_q       <= err_d;
`ifdef DATA_ARB_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

  // Memory-side outputs are decoded from registers only, so an async reset
  // drops the strobes immediately.
  assign active_s        = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign strobe_s        = active_s ? strobe_for(we_q) : STROBE_NONE;
  assign mem_memread_o   = strobe_s[0];
  assign mem_memwrite_o  = strobe_s[1];
  assign mem_addr_o      = active_s ? addr_q  : '0;
  assign mem_wdata_o     = active_s ? wdata_q : '0;
  assign mem_sign_mask_o = active_s ? mask_q  : 4'h0;

  assign cpu_rdata_o   = cpu_rdata_q;
  assign dma_rdata_o   = dma_rdata_q;
  assign err_timeout_o = err_q;
  assign dma_ack_o     = (state_q == ST_DONE) && (owner_q == OWN_DMA);
  assign cpu_stall_o   = cpu_req_i & ~((state_q == ST_DONE) && (owner_q == OWN_CPU));

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: stimulus queues expected completions,
// a negedge monitor pops and checks them when ack / stall release appears.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_mask;
  logic        dma_req, dma_we, dma_ack;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic [3:0]  dma_mask;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_mask;
  logic        mem_rd, mem_wr, mem_busy, err_to;

  typedef struct {
    logic        is_dma;
    logic        chk_data;
    logic [31:0] data;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   t0       = 0;

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cpu_req_i       (cpu_req),
    .cpu_we_i        (cpu_we),
    .cpu_addr_i      (cpu_addr),
    .cpu_wdata_i     (cpu_wdata),
    .cpu_sign_mask_i (cpu_mask),
    .cpu_rdata_o     (cpu_rdata),
    .cpu_stall_o     (cpu_stall),
    .dma_req_i       (dma_req),
    .dma_we_i        (dma_we),
    .dma_addr_i      (dma_addr),
    .dma_wdata_i     (dma_wdata),
    .dma_sign_mask_i (dma_mask),
    .dma_rdata_o     (dma_rdata),
    .dma_ack_o       (dma_ack),
    .mem_addr_o      (mem_addr),
    .mem_wdata_o     (mem_wdata),
    .mem_sign_mask_o (mem_mask),
    .mem_memread_o   (mem_rd),
    .mem_memwrite_o  (mem_wr),
    .mem_read_data_i (mem_rdata),
    .mem_busy_i      (mem_busy),
    .err_timeout_o   (err_to)
  );

  always #5 clk = ~clk;

  // Memory returns the bitwise inverse of the address it is given.
  assign mem_rdata = ~mem_addr;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_done(input logic is_dma, input logic chk_data,
                             input logic [31:0] data, input int n);
    exp_t e;
    e.is_dma   = is_dma;
    e.chk_data = chk_data;
    e.data     = data;
    e.at       = t0 + n;
    sb.push_back(e);
  endtask

  task automatic check_event(input logic is_dma, input logic [31:0] data);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_completion: got is_dma=%0b at cyc %0d expected none", is_dma, cyc);
    end else begin
      e = sb.pop_front();
      chk("owner", {31'd0, is_dma}, {31'd0, e.is_dma});
      chk("done_cycle", cyc, e.at);
      if (e.chk_data) begin
        chk("rdata", data, e.data);
      end
    end
  endtask

  // Monitor: a completion is dma_ack, or cpu_req with stall released.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      if (dma_ack === 1'b1) check_event(1'b1, dma_rdata);
      if (cpu_req === 1'b1 && cpu_stall === 1'b0) check_event(1'b0, cpu_rdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic to_cycle(input int n);
    while (cyc < t0 + n) @(negedge clk);
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_mask = 4'h0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0; dma_mask = 4'h0;
    mem_busy = 1'b0;
    repeat (3) step();
    chk("rst_memread", mem_rd, 32'd0);
    chk("rst_memwrite", mem_wr, 32'd0);
    chk("rst_dma_ack", dma_ack, 32'd0);
    chk("rst_err", err_to, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_dma_rdata", dma_rdata, 32'h0);
    rst_n = 1'b1;
    step();

    // 1: single CPU read returning DEADBEEF, minimum latency
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h2152_4110; cpu_mask = 4'hF;
    t0 = cyc;
    expect_done(1'b0, 1'b1, 32'hDEAD_BEEF, 3);
    #1 chk("stall_first_cycle", cpu_stall, 32'd1);
    to_cycle(1);
    chk("t1_rd_c1", mem_rd, 32'd1);
    chk("t1_wr_c1", mem_wr, 32'd0);
    chk("t1_addr_c1", mem_addr, 32'h2152_4110);
    chk("t1_mask_c1", mem_mask, 32'hF);
    to_cycle(2);
    chk("t1_rd_c2", mem_rd, 32'd1);
    chk("t1_stall_c2", cpu_stall, 32'd1);
    to_cycle(3);
    chk("t1_rd_c3", mem_rd, 32'd0);
    chk("t1_addr_c3", mem_addr, 32'h0);
    step();
    cpu_req = 1'b0;
    drain(5);

    // 2: DMA write to 0x1000 with busy held for 4 WAIT cycles
    step();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h0000_1000; dma_wdata = 32'hCAFE_F00D;
    dma_mask = 4'h3; mem_busy = 1'b1;
    t0 = cyc;
    expect_done(1'b1, 1'b0, 32'h0, 7);
    to_cycle(1);
    chk("t2_wr_c1", mem_wr, 32'd1);
    chk("t2_rd_c1", mem_rd, 32'd0);
    to_cycle(5);
    chk("t2_wr_c5", mem_wr, 32'd1);
    chk("t2_wdata", mem_wdata, 32'hCAFE_F00D);
    chk("t2_addr", mem_addr, 32'h0000_1000);
    chk("t2_mask", mem_mask, 32'h3);
    step();
    mem_busy = 1'b0;
    to_cycle(6);
    chk("t2_wr_c6", mem_wr, 32'd1);
    to_cycle(7);
    chk("t2_wr_c7", mem_wr, 32'd0);
    chk("t2_err", err_to, 32'd0);
    step();
    dma_req = 1'b0; dma_we = 1'b0;
    drain(5);

    // 3: continuous contention, four completions
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0100;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h0000_0200;
    t0 = cyc;
`ifdef DATA_ARB_ROUND_ROBIN_EN
    expect_done(1'b0, 1'b1, 32'hFFFF_FEFF, 3);
    expect_done(1'b1, 1'b1, 32'hFFFF_FDFF, 7);
    expect_done(1'b0, 1'b1, 32'hFFFF_FEFF, 11);
    expect_done(1'b1, 1'b1, 32'hFFFF_FDFF, 15);
`else
    expect_done(1'b0, 1'b1, 32'hFFFF_FEFF, 3);
    expect_done(1'b0, 1'b1, 32'hFFFF_FEFF, 7);
    expect_done(1'b0, 1'b1, 32'hFFFF_FEFF, 11);
    expect_done(1'b0, 1'b1, 32'hFFFF_FEFF, 15);
`endif
    to_cycle(15);
    step();
    cpu_req = 1'b0; dma_req = 1'b0;
    drain(5);

    // 4: busy stuck high -> watchdog after 15 WAIT cycles
    step();
    cpu_req = 1'b1; cpu_addr = 32'h0000_0300; mem_busy = 1'b1;
    t0 = cyc;
    expect_done(1'b0, 1'b1, 32'h0, 17);
    to_cycle(16);
    chk("t4_err_c16", err_to, 32'd0);
    chk("t4_rd_c16", mem_rd, 32'd1);
    to_cycle(17);
    chk("t4_err_c17", err_to, 32'd1);
    chk("t4_rd_c17", mem_rd, 32'd0);
    step();
    cpu_req = 1'b0; mem_busy = 1'b0;
    drain(5);
    step();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h0000_0400;
    t0 = cyc;
    expect_done(1'b1, 1'b1, 32'hFFFF_FBFF, 3);
    to_cycle(3);
    chk("t4_err_sticky", err_to, 32'd1);
    step();
    dma_req = 1'b0;
    drain(5);

    // 5: reset pulse during WAIT, request re-served afterwards
    step();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h0000_0500; mem_busy = 1'b1;
    t0 = cyc;
    to_cycle(3);
    chk("t5_rd_wait", mem_rd, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rd_rst", mem_rd, 32'd0);
    chk("t5_addr_rst", mem_addr, 32'h0);
    chk("t5_ack_rst", dma_ack, 32'd0);
    chk("t5_err_rst", err_to, 32'd0);
    step();
    mem_busy = 1'b0;
    rst_n = 1'b1;
    t0 = cyc;
    expect_done(1'b1, 1'b1, 32'hFFFF_FAFF, 3);
    to_cycle(3);
    step();
    dma_req = 1'b0;
    drain(5);
    repeat (4) step();
    chk("final_queue_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
